// File: rtl/demux_5bits_8saidas.sv
// Registered 1-to-8 demultiplexer for 5-bit register addresses.
// An incoming value is steered by a 3-bit key into one of eight single-entry
// slots; each slot keeps its value flagged valid until its consumer accepts it.
// The input side uses valid/ready, the output side valid/accept per slot, and
// a registered occupancy count is provided for downstream stall logic.

`timescale 1ns/1ps

module demux_5bits_8saidas #(
    parameter int LARGURA = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    input  logic [2:0]         key,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    input  logic               limpar,
    output logic [LARGURA-1:0] saida1,
    output logic [LARGURA-1:0] saida2,
    output logic [LARGURA-1:0] saida3,
    output logic [LARGURA-1:0] saida4,
    output logic [LARGURA-1:0] saida5,
    output logic [LARGURA-1:0] saida6,
    output logic [LARGURA-1:0] saida7,
    output logic [LARGURA-1:0] saida8,
    output logic [7:0]         saida_valida,
    input  logic [7:0]         saida_aceita,
    output logic [3:0]         ocupados
);

    logic [LARGURA-1:0] slots [8];
    logic               carga;
    logic [7:0]         valida_prox;
    logic [3:0]         ocupados_prox;

    // The addressed slot can take a new value when it is empty or being drained this same cycle; a flush blocks all loads.
    always_comb begin
        entrada_pronta = 1'b0;
        if (!limpar) begin
            entrada_pronta = ~saida_valida[key] | saida_aceita[key];
        end
    end

    assign carga = entrada_valida & entrada_pronta;

    // Next valid vector: accepts clear, a load sets its slot (winning over its own accept), and a flush clears everything.
    always_comb begin
        valida_prox = saida_valida & ~saida_aceita;
        if (carga) begin
            valida_prox[key] = 1'b1;
        end
        if (limpar) begin
            valida_prox = 8'h00;
        end
    end

    // Occupancy is the population count of the next valid vector so both registers always agree.
    always_comb begin
        ocupados_prox = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ocupados_prox = ocupados_prox + {3'b000, valida_prox[i]};
        end
    end

    // Slot data registers: only the addressed slot loads on a transfer; accepts and flushes leave data untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                slots[i] <= '0;
            end
        end else if (carga) begin
            slots[key] <= entrada;
        end
    end

    // Valid flags and occupancy count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida_valida <= 8'h00;
            ocupados     <= 4'd0;
        end else begin
            saida_valida <= valida_prox;
            ocupados     <= ocupados_prox;
        end
    end

    assign saida1 = slots[0];
    assign saida2 = slots[1];
    assign saida3 = slots[2];
    assign saida4 = slots[3];
    assign saida5 = slots[4];
    assign saida6 = slots[5];
    assign saida7 = slots[6];
    assign saida8 = slots[7];

endmodule

// File: tb/tb_demux_5bits_8saidas.sv
// Directed testbench for demux_5bits_8saidas: fill, drain, pass-through,
// independent load/accept, flush and asynchronous reset scenarios.

`timescale 1ns/1ps

module tb_demux_5bits_8saidas;

    logic       clock;
    logic       reset;
    logic [4:0] entrada;
    logic [2:0] key;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic       limpar;
    logic [4:0] s [8];
    logic [7:0] saida_valida;
    logic [7:0] saida_aceita;
    logic [3:0] ocupados;

    int errors = 0;
    int checks = 0;

    demux_5bits_8saidas #(.LARGURA(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada        (entrada),
        .key            (key),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .limpar         (limpar),
        .saida1         (s[0]),
        .saida2         (s[1]),
        .saida3         (s[2]),
        .saida4         (s[3]),
        .saida5         (s[4]),
        .saida6         (s[5]),
        .saida7         (s[6]),
        .saida8         (s[7]),
        .saida_valida   (saida_valida),
        .saida_aceita   (saida_aceita),
        .ocupados       (ocupados)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] e, input logic [2:0] k, input logic v,
                                 input logic [7:0] a, input logic l);
        entrada        = e;
        key            = k;
        entrada_valida = v;
        saida_aceita   = a;
        limpar         = l;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Linear sequence of directed steps.
    initial begin
        reset = 1'b0;
        applyStimulus(5'($urandom), 3'($urandom), 1'b1, 8'($urandom), 1'b0);

        tick();
        applyStimulus(5'($urandom), 3'($urandom), 1'b1, 8'($urandom), 1'b1);
        tick();
        checkOutput("reset_valida", 32'(saida_valida), 32'h00);
        checkOutput("reset_ocupados", 32'(ocupados), 32'd0);

        reset = 1'b1;
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("reset_pronta", 32'(entrada_pronta), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("reset_saida%0d", i + 1), 32'(s[i]), 32'd0);
        end

        // Fill every slot in order with no accepts.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(5'(k + 10), 3'(k), 1'b1, 8'h00, 1'b0);
            #1;
            checkOutput($sformatf("fill_pronta%0d", k), 32'(entrada_pronta), 32'd1);
            tick();
            checkOutput($sformatf("fill_saida%0d", k + 1), 32'(s[k]), 32'(k + 10));
        end
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("full_valida", 32'(saida_valida), 32'hFF);
        checkOutput("full_ocupados", 32'(ocupados), 32'd8);

        // Offer to a full slot without an accept: must stall.
        applyStimulus(5'd30, 3'd3, 1'b1, 8'h00, 1'b0);
        #1;
        checkOutput("stall_pronta", 32'(entrada_pronta), 32'd0);
        tick();
        checkOutput("stall_saida4", 32'(s[3]), 32'd13);
        checkOutput("stall_valida", 32'(saida_valida), 32'hFF);

        // Drain slots 1 and 3.
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h05, 1'b0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("drain_valida", 32'(saida_valida), 32'hFA);
        checkOutput("drain_ocupados", 32'(ocupados), 32'd6);
        checkOutput("drain_saida1", 32'(s[0]), 32'd10);
        checkOutput("drain_saida3", 32'(s[2]), 32'd12);

        // Pass-through on slot 5: replace 15 with 7, then 7 with 21.
        applyStimulus(5'd7, 3'd5, 1'b1, 8'h20, 1'b0);
        #1;
        checkOutput("pass1_pronta", 32'(entrada_pronta), 32'd1);
        tick();
        checkOutput("pass1_saida6", 32'(s[5]), 32'd7);
        applyStimulus(5'd21, 3'd5, 1'b1, 8'h20, 1'b0);
        #1;
        checkOutput("pass2_pronta", 32'(entrada_pronta), 32'd1);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("pass2_saida6", 32'(s[5]), 32'd21);
        checkOutput("pass2_valida", 32'(saida_valida), 32'hFA);
        checkOutput("pass2_ocupados", 32'(ocupados), 32'd6);

        // Load slot 0 while accepting slot 3 in the same cycle.
        applyStimulus(5'd9, 3'd0, 1'b1, 8'h08, 1'b0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("indep_saida1", 32'(s[0]), 32'd9);
        checkOutput("indep_valida", 32'(saida_valida), 32'hF3);
        checkOutput("indep_ocupados", 32'(ocupados), 32'd6);

        // Accept on an empty slot is ignored.
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h04, 1'b0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("ignore_valida", 32'(saida_valida), 32'hF3);

        // Flush with a simultaneous offer and accepts.
        applyStimulus(5'd25, 3'd2, 1'b1, 8'hFF, 1'b1);
        #1;
        checkOutput("flush_pronta", 32'(entrada_pronta), 32'd0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("flush_valida", 32'(saida_valida), 32'h00);
        checkOutput("flush_ocupados", 32'(ocupados), 32'd0);
        checkOutput("flush_saida3", 32'(s[2]), 32'd12);

        // Fill slots 1 and 2, then assert reset between edges.
        applyStimulus(5'd3, 3'd1, 1'b1, 8'h00, 1'b0);
        tick();
        applyStimulus(5'd4, 3'd2, 1'b1, 8'h00, 1'b0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_async_valida", 32'(saida_valida), 32'h06);
        checkOutput("pre_async_ocupados", 32'(ocupados), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_valida", 32'(saida_valida), 32'h00);
        checkOutput("async_ocupados", 32'(ocupados), 32'd0);
        checkOutput("async_saida2", 32'(s[1]), 32'd0);
        checkOutput("async_saida3", 32'(s[2]), 32'd0);
        #2;
        reset = 1'b1;
        tick();

        // Load after release.
        applyStimulus(5'd31, 3'd1, 1'b1, 8'h00, 1'b0);
        tick();
        applyStimulus(5'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_saida2", 32'(s[1]), 32'd31);
        checkOutput("post_valida", 32'(saida_valida), 32'h02);
        checkOutput("post_ocupados", 32'(ocupados), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
